// File: rtl/md_seq_ctrl.sv
// Multiply/divide sequencer: iterative 32-step shift-add multiplier and restoring
// divider that stalls IF/ID while busy and shares the reg_bank write port with WB.
module md_seq_ctrl #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [2:0]            funct3_i,
    input  logic [WORD_WIDTH-1:0] op_a_i,
    input  logic [WORD_WIDTH-1:0] op_b_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic                  flush_i,
    input  logic                  wb_wen_i,
    input  logic [ADDR_WIDTH-1:0] wb_waddr_i,
    input  logic [WORD_WIDTH-1:0] wb_wdata_i,
    output logic                  rf_wen_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [WORD_WIDTH-1:0] rf_wdata_o,
    output logic                  stall_o,
    output logic                  busy_o
);

    localparam int W  = WORD_WIDTH;
    localparam int CW = $clog2(WORD_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [2*W-1:0]        acc_q, acc_d;
    logic [W-1:0]          opa_q, opa_d;
    logic [W-1:0]          opb_q, opb_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                  neg_q, neg_d;
    logic                  special_q, special_d;
    logic [W-1:0]          special_res_q, special_res_d;
    logic [W-1:0]          result_q, result_d;

    // Operand preparation for the instruction currently presented in ID
    logic          sign_a, sign_b, signed_a, signed_b, is_div;
    logic [W-1:0]  abs_a, abs_b;
    logic          neg_in, div_zero_in, ovf_in;

    always_comb begin
        sign_a      = op_a_i[W-1];
        sign_b      = op_b_i[W-1];
        is_div      = funct3_i[2];
        signed_a    = (funct3_i == 3'd1) || (funct3_i == 3'd2) ||
                      (funct3_i == 3'd4) || (funct3_i == 3'd6);
        signed_b    = (funct3_i == 3'd1) || (funct3_i == 3'd4) || (funct3_i == 3'd6);
        abs_a       = (signed_a && sign_a) ? (~op_a_i + 1'b1) : op_a_i;
        abs_b       = (signed_b && sign_b) ? (~op_b_i + 1'b1) : op_b_i;
        div_zero_in = is_div && (op_b_i == '0);
        ovf_in      = (funct3_i == 3'd4 || funct3_i == 3'd6) &&
                      (op_a_i == {1'b1, {(W-1){1'b0}}}) && (op_b_i == '1);
        case (funct3_i)
            3'd1, 3'd4: neg_in = sign_a ^ sign_b;
            3'd2, 3'd6: neg_in = sign_a;
            default:    neg_in = 1'b0;
        endcase
    end

    // One iteration of the multiply or divide datapath
    logic [W:0]     mul_sum;
    logic [W:0]     rem_sh;
    logic [W:0]     rem_diff;
    logic [2*W-1:0] acc_step;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix, calc_res;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opa_q} : '0);
        rem_sh   = acc_q[2*W-1:W-1];
        rem_diff = rem_sh - {1'b0, opb_q};
        if (funct3_q[2]) begin
            if (!rem_diff[W])
                acc_step = {rem_diff[W-1:0], acc_q[W-2:0], 1'b1};
            else
                acc_step = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc_q[W-1:1]};
        end
        prod_fix = neg_q ? (~acc_step + 1'b1) : acc_step;
        quo_fix  = neg_q ? (~acc_step[W-1:0] + 1'b1) : acc_step[W-1:0];
        rem_fix  = neg_q ? (~acc_step[2*W-1:W] + 1'b1) : acc_step[2*W-1:W];
        case (funct3_q)
            3'd0:             calc_res = prod_fix[W-1:0];
            3'd1, 3'd2, 3'd3: calc_res = prod_fix[2*W-1:W];
            3'd4, 3'd5:       calc_res = quo_fix;
            default:          calc_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        acc_d         = acc_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        funct3_d      = funct3_q;
        rd_d          = rd_q;
        neg_d         = neg_q;
        special_d     = special_q;
        special_res_d = special_res_q;
        result_d      = result_q;
        rf_wen_o      = wb_wen_i;
        rf_waddr_o    = wb_waddr_i;
        rf_wdata_o    = wb_wdata_i;
        stall_o       = 1'b0;

        case (state_q)
            IDLE: begin
                stall_o = start_i;
                if (start_i && !flush_i) begin
                    state_d       = CALC;
                    count_d       = CW'(WORD_WIDTH - 1);
                    opa_d         = abs_a;
                    opb_d         = abs_b;
                    acc_d         = {{W{1'b0}}, is_div ? abs_a : abs_b};
                    funct3_d      = funct3_i;
                    rd_d          = rd_addr_i;
                    neg_d         = neg_in;
                    special_d     = div_zero_in || ovf_in;
                    // Divide-by-zero and overflow results are fixed; the loop still runs
                    if (div_zero_in)
                        special_res_d = funct3_i[1] ? op_a_i : '1;
                    else
                        special_res_d = funct3_i[1] ? '0 : {1'b1, {(W-1){1'b0}}};
                end
            end
            CALC: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d   = acc_step;
                    count_d = count_q - 1'b1;
                    if (count_q == '0) begin
                        state_d  = WRITE;
                        result_d = special_q ? special_res_q : calc_res;
                    end
                end
            end
            WRITE: begin
                if (flush_i) begin
                    stall_o = 1'b1;
                    state_d = IDLE;
                end else if (wb_wen_i) begin
                    stall_o = 1'b1;
                end else begin
                    rf_wen_o   = (rd_q != '0);
                    rf_waddr_o = rd_q;
                    rf_wdata_o = result_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            count_q       <= '0;
            acc_q         <= '0;
            opa_q         <= '0;
            opb_q         <= '0;
            funct3_q      <= '0;
            rd_q          <= '0;
            neg_q         <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= '0;
            result_q      <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            acc_q         <= acc_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            funct3_q      <= funct3_d;
            rd_q          <= rd_d;
            neg_q         <= neg_d;
            special_q     <= special_d;
            special_res_q <= special_res_d;
            result_q      <= result_d;
        end
    end

endmodule

// File: doc/md_seq_ctrl.md
Name: md_seq_ctrl

Overview:
- Sequencer for multiply/divide instructions flagged by the decoder's md_op control.
- Runs an iterative 32-step shift-add multiplier / restoring divider and stalls the front end (IF/ID) while busy.
- Arbitrates the single register-bank write port between the normal WB path and the MD result.
- Sits between the ID stage outputs and the reg_bank write port, replacing the direct WB-to-reg_bank connection.

Parameters:
- WORD_WIDTH, 32, operand/result width; the iteration count equals WORD_WIDTH.
- ADDR_WIDTH, 5, register address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  MD instruction valid in ID (md_op_ctrl & valid)
- funct3_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- op_a_i  in  WORD_WIDTH  rs1 value
- op_b_i  in  WORD_WIDTH  rs2 value
- rd_addr_i  in  ADDR_WIDTH  destination register
- flush_i  in  1  pipeline flush; aborts the operation in progress
- wb_wen_i  in  1  WB write enable
- wb_waddr_i  in  ADDR_WIDTH  WB write address
- wb_wdata_i  in  WORD_WIDTH  WB write data
- rf_wen_o  out  1  write enable to reg_bank
- rf_waddr_o  out  ADDR_WIDTH  write address to reg_bank
- rf_wdata_o  out  WORD_WIDTH  write data to reg_bank
- stall_o  out  1  hold IF/ID
- busy_o  out  1  state != IDLE

Behaviour:
- Clocking and reset: one clock; reset is asynchronous, active-low (rst_n). Reset clears state to IDLE, count to 0 and all result/operand registers to 0.
- States: IDLE, CALC, WRITE.
- IDLE:
  - stall_o = start_i (combinational).
  - If start_i and !flush_i: latch operands, funct3 and rd, and go to CALC with count = WORD_WIDTH-1.
- Operand preparation at latch: signed ops take absolute values. Negation flags:
  - MULH: sign(a)^sign(b)
  - MULHSU: sign(a)
  - DIV: sign(a)^sign(b)
  - REM: sign(a)
- CALC:
  - One shift-add (MUL) or restoring subtract-shift (DIV) step per cycle, using a 2*WORD_WIDTH-bit accumulator.
  - Decrement count. At count == 0, apply sign fix and go to WRITE.
  - stall_o = 1.
- Results:
  - MUL: low word.
  - MULH*: high word.
  - DIV*: quotient.
  - REM*: remainder.
- Special cases, detected at latch. These still take the full 32 cycles, so latency is fixed.
  - Divide by zero: quotient = all ones, remainder = op_a.
  - Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
- WRITE:
  - WB has priority. If wb_wen_i, pass WB through and stay in WRITE with stall_o = 1.
  - Otherwise drive rf_wen_o = (rd != 0), rf_waddr_o = rd and rf_wdata_o = result. Deassert stall_o in this cycle and go to IDLE next.
- Port pass-through: outside WRITE-with-grant, rf_* = wb_* unconditionally in all states.
- Latency: start accepted at edge 0 → 32 CALC cycles → WRITE. With no WB conflict, stall_o is high for 33 cycles and the write happens in cycle 33.
- flush_i in CALC or WRITE: return to IDLE next edge with no MD write. stall_o drops in the cycle after flush.
- start_i in non-IDLE states is ignored. ID is stalled, so the same instruction is re-presented and is accepted only on return to IDLE if it is still asserted. The decoder must hold start_i low after the stall releases; the stall release coincides with ID advancing.
- rd == 0: full sequence runs but rf_wen_o stays 0 for the MD result.

Test Plan:
1. Reset mid-CALC (rst_n low at cycle 10): busy_o, stall_o and rf_wen_o go to 0 immediately (asynchronous reset); no write occurs after release.
2. MUL 7 * -3 (funct3 = 0), rd = 5, no WB traffic: stall_o high for 33 cycles; in cycle 33 rf_wen_o = 1, rf_waddr_o = 5, rf_wdata_o = 0xFFFFFFEB.
3. MULHU 0xFFFFFFFF * 0xFFFFFFFF → result 0xFFFFFFFE; MULH 0x80000000 * 0x80000000 → result 0x40000000.
4. DIV -7 / 2 → quotient 0xFFFFFFFD; REM -7 / 2 → remainder 0xFFFFFFFF; DIVU x / 0 → 0xFFFFFFFF; REM 0x80000000 / -1 → 0.
5. WB conflict: wb_wen_i held high for 3 cycles starting when WRITE is entered → WB data written on all 3 cycles, stall_o stays high, MD write occurs on the 4th cycle.
6. flush_i at cycle 20 of CALC → IDLE next edge, no MD write, and WB pass-through is unaffected throughout.
